remote_cmd_issuer: RTL and testbench

- Remote-panel end of the WIFI command link: turns debounced operator buttons into the 4-bit inWIFI command codes consumed by the alarm FSM.
- Holds each code on the wire for a fixed window, then confirms the FSM reached the expected state via its 2-bit status, with bounded retries.
- Also synchronises the FSM's outWIFI alarm flag and emits a rising-edge notification.

---
 rtl/security_pkg.sv | 54 +++++
 rtl/btn_debounce.sv | 41 ++++
 rtl/remote_cmd_issuer.sv | 160 ++++++++++++++++
 tb/tb_remote_cmd_issuer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/security_pkg.sv
// Shared encodings for the alarm FSM WIFI link: status codes, command codes,
// and the request selector used by the remote command issuer.
package security_pkg;

    localparam logic [1:0] STATE_INACTIVE  = 2'b00;
    localparam logic [1:0] STATE_ACTIVE    = 2'b01;
    localparam logic [1:0] STATE_ALARM     = 2'b10;
    localparam logic [1:0] STATE_EMERGENCY = 2'b11;

    localparam logic [3:0] CMD_IDLE     = 4'b0000;
    localparam logic [3:0] CMD_DISARM   = 4'b1010;
    localparam logic [3:0] CMD_REARM    = 4'b1011;
    localparam logic [3:0] CMD_ESCALATE = 4'b1100;

    typedef enum logic [1:0] {
        ISS_IDLE  = 2'd0,
        ISS_DRIVE = 2'd1,
        ISS_WAIT  = 2'd2
    } issuer_state_e;

    typedef struct packed {
        logic       valid;
        logic       legal;
        logic [3:0] code;
        logic [1:0] expect_state;
    } cmd_req_t;

    // Priority disarm > rearm > escalate; legality judged on the current FSM status.
    function automatic cmd_req_t select_request(input logic       disarm,
                                                 input logic       rearm,
                                                 input logic       escalate,
                                                 input logic [1:0] fsm_state);
        cmd_req_t r;
        r = '{valid: 1'b0, legal: 1'b0, code: CMD_IDLE, expect_state: STATE_INACTIVE};
        if (disarm) begin
            r.valid        = 1'b1;
            r.legal        = (fsm_state == STATE_ALARM) || (fsm_state == STATE_EMERGENCY);
            r.code         = CMD_DISARM;
            r.expect_state = STATE_INACTIVE;
        end else if (rearm) begin
            r.valid        = 1'b1;
            r.legal        = (fsm_state == STATE_ALARM) || (fsm_state == STATE_EMERGENCY);
            r.code         = CMD_REARM;
            r.expect_state = STATE_ACTIVE;
        end else if (escalate) begin
            r.valid        = 1'b1;
            r.legal        = (fsm_state == STATE_ALARM);
            r.code         = CMD_ESCALATE;
            r.expect_state = STATE_EMERGENCY;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchroniser -> stability counter -> one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic req
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2, level;
    logic [CW-1:0] cnt;
    logic          settle_c;

    // Level flips on the last of DEBOUNCE_CYCLES consecutive disagreeing cycles.
    assign settle_c = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            req   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (settle_c) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
            req <= settle_c & sync2;
        end
    end

endmodule

// File: rtl/remote_cmd_issuer.sv
// Remote-panel side of the WIFI link: issues held command codes, confirms them
// against the FSM status with bounded retries, and flags alarm rising edges.
module remote_cmd_issuer
    import security_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 4,
    parameter int unsigned ACK_TIMEOUT     = 50000000,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_disarm,
    input  logic       btn_rearm,
    input  logic       btn_escalate,
    input  logic [1:0] state_in,
    input  logic       alarm_in,
    output logic [3:0] cmd_code,
    output logic       busy,
    output logic       ack_ok,
    output logic       fail,
    output logic       reject,
    output logic [1:0] retry_cnt,
    output logic       alarm_rise
);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    logic     req_disarm, req_rearm, req_escalate;
    cmd_req_t req_c;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_disarm (
        .clk(clk), .reset(reset), .btn(btn_disarm), .req(req_disarm));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rearm (
        .clk(clk), .reset(reset), .btn(btn_rearm), .req(req_rearm));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_escalate (
        .clk(clk), .reset(reset), .btn(btn_escalate), .req(req_escalate));

    assign req_c = select_request(req_disarm, req_rearm, req_escalate, state_in);

    issuer_state_e state_q, state_n;
    logic [3:0]    code_q, code_n;
    logic [1:0]    exp_state_q, exp_state_n;
    logic [HW-1:0] hold_q, hold_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [1:0]    retry_n;
    logic [3:0]    cmd_n;
    logic          busy_n, ack_n, fail_n, reject_n;

    // Next state plus next value of every registered output.
    always_comb begin
        state_n     = state_q;
        code_n      = code_q;
        exp_state_n = exp_state_q;
        hold_n      = hold_q;
        timer_n     = timer_q;
        retry_n     = retry_cnt;
        cmd_n       = CMD_IDLE;
        busy_n      = 1'b0;
        ack_n       = 1'b0;
        fail_n      = 1'b0;
        reject_n    = 1'b0;
        case (state_q)
            ISS_IDLE: begin
                if (req_c.valid && req_c.legal) begin
                    state_n     = ISS_DRIVE;
                    code_n      = req_c.code;
                    exp_state_n = req_c.expect_state;
                    retry_n     = '0;
                    cmd_n       = req_c.code;
                    busy_n      = 1'b1;
                end else if (req_c.valid) begin
                    reject_n = 1'b1;
                end
            end
            ISS_DRIVE: begin
                reject_n = req_c.valid;
                busy_n   = 1'b1;
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_n = ISS_WAIT;
                end else begin
                    hold_n = hold_q + HW'(1);
                    cmd_n  = code_q;
                end
            end
            ISS_WAIT: begin
                reject_n = req_c.valid;
                // A match wins over a simultaneous timeout.
                if (state_in == exp_state_q) begin
                    ack_n   = 1'b1;
                    state_n = ISS_IDLE;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    if (retry_cnt < 2'(MAX_RETRY)) begin
                        retry_n = retry_cnt + 2'd1;
                        state_n = ISS_DRIVE;
                        cmd_n   = code_q;
                        busy_n  = 1'b1;
                    end else begin
                        fail_n  = 1'b1;
                        state_n = ISS_IDLE;
                    end
                end else begin
                    timer_n = timer_q + TW'(1);
                    busy_n  = 1'b1;
                end
            end
            default: state_n = ISS_IDLE;
        endcase
        if (state_n != state_q) begin
            hold_n  = '0;
            timer_n = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ISS_IDLE;
            code_q      <= CMD_IDLE;
            exp_state_q <= STATE_INACTIVE;
            hold_q      <= '0;
            timer_q     <= '0;
            retry_cnt   <= '0;
            cmd_code    <= CMD_IDLE;
            busy        <= 1'b0;
            ack_ok      <= 1'b0;
            fail        <= 1'b0;
            reject      <= 1'b0;
        end else begin
            state_q     <= state_n;
            code_q      <= code_n;
            exp_state_q <= exp_state_n;
            hold_q      <= hold_n;
            timer_q     <= timer_n;
            retry_cnt   <= retry_n;
            cmd_code    <= cmd_n;
            busy        <= busy_n;
            ack_ok      <= ack_n;
            fail        <= fail_n;
            reject      <= reject_n;
        end
    end

    // outWIFI alarm flag: synchronise, then pulse on the rising edge only.
    logic alarm_s1, alarm_s2, alarm_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_s1   <= 1'b0;
            alarm_s2   <= 1'b0;
            alarm_d    <= 1'b0;
            alarm_rise <= 1'b0;
        end else begin
            alarm_s1   <= alarm_in;
            alarm_s2   <= alarm_s1;
            alarm_d    <= alarm_s2;
            alarm_rise <= alarm_s2 & ~alarm_d;
        end
    end

endmodule

// File: tb/tb_remote_cmd_issuer.sv
// Self-checking bench for remote_cmd_issuer: directed scenarios plus randomized
// button/state/response sequences checked against a window-arithmetic model.
module tb_remote_cmd_issuer;
    import security_pkg::*;

    localparam int DC     = 4;
    localparam int HOLD   = 2;
    localparam int ACK_TO = 16;
    localparam int MAXR   = 2;
    localparam int LAT    = 2 + DC + 1;   // sync stages + stable window + command register
    localparam int PERIOD = ACK_TO + HOLD;
    localparam int WIN    = 80;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_disarm, btn_rearm, btn_escalate;
    logic [1:0] state_in;
    logic       alarm_in;
    logic [3:0] cmd_code;
    logic       busy, ack_ok, fail, reject, alarm_rise;
    logic [1:0] retry_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    remote_cmd_issuer #(
        .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(ACK_TO), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_disarm(btn_disarm), .btn_rearm(btn_rearm), .btn_escalate(btn_escalate),
        .state_in(state_in), .alarm_in(alarm_in),
        .cmd_code(cmd_code), .busy(busy), .ack_ok(ack_ok), .fail(fail), .reject(reject),
        .retry_cnt(retry_cnt), .alarm_rise(alarm_rise)
    );

    typedef struct {
        int         bursts;
        int         code_cycles;
        int         bad_code;
        int         acks;
        int         fails;
        int         rejects;
        int         first_cmd;
        int         busy_cycles;
        logic       busy_at_ack;
        logic       busy_end;
        logic [1:0] retry_end;
    } obs_t;

    // Response d cycles after the first hold window ends: which attempt sees it.
    function automatic void model_resp(input int d, output int bursts, output bit acked,
                                       output int retries);
        int attempt;
        attempt = d / PERIOD + (((d % PERIOD) < ACK_TO) ? 0 : 1);
        if (attempt <= MAXR) begin
            bursts = attempt + 1; acked = 1'b1; retries = attempt;
        end else begin
            bursts = MAXR + 1; acked = 1'b0; retries = MAXR;
        end
    endfunction

    // Watches WIN cycles after a press; answers with resp_val resp_d cycles after the first burst.
    task automatic observe(input logic [3:0] code, input int resp_d, input logic [1:0] resp_val,
                           input int rearm_rel, input int rearm_press, output obs_t o);
        int         end_c;
        logic [3:0] prev;
        o = '{default: 0};
        o.first_cmd = -1;
        end_c = -1;
        prev = CMD_IDLE;
        for (int c = 1; c <= WIN; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (cmd_code !== CMD_IDLE && cmd_code !== code) o.bad_code++;
            if (code != CMD_IDLE && cmd_code === code) begin
                o.code_cycles++;
                if (prev !== code) o.bursts++;
                if (o.first_cmd < 0) o.first_cmd = c;
            end
            if (code != CMD_IDLE && cmd_code === CMD_IDLE && prev === code && end_c < 0) end_c = c;
            if (ack_ok === 1'b1) begin o.acks++; o.busy_at_ack = busy; end
            if (fail === 1'b1) o.fails++;
            if (reject === 1'b1) o.rejects++;
            if (busy === 1'b1) o.busy_cycles++;
            if (end_c >= 0 && c == end_c + resp_d) state_in = resp_val;
            if (c == rearm_rel) btn_rearm = 1'b0;
            if (c == rearm_press) btn_rearm = 1'b1;
            prev = cmd_code;
        end
        o.busy_end  = busy;
        o.retry_end = retry_cnt;
    endtask

    task automatic release_all();
        btn_disarm = 1'b0; btn_rearm = 1'b0; btn_escalate = 1'b0;
        repeat (DC + 8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_disarm = 1'b0; btn_rearm = 1'b0; btn_escalate = 1'b0;
        state_in = STATE_INACTIVE; alarm_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (cmd_code !== CMD_IDLE) begin n_fail++; $display("FAIL reset_cmd: got %b want %b", cmd_code, CMD_IDLE); end
        n_tests++;
        if ({busy, ack_ok, fail, reject, alarm_rise, retry_cnt} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000", {busy, ack_ok, fail, reject, alarm_rise, retry_cnt});
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_disarm();
        obs_t o;
        state_in = STATE_ALARM;
        @(posedge clk); #1 btn_disarm = 1'b1;
        observe(CMD_DISARM, 3, STATE_INACTIVE, -1, -1, o);
        n_tests++; if (o.first_cmd !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", o.first_cmd, LAT); end
        n_tests++; if (o.code_cycles !== HOLD || o.bursts !== 1) begin n_fail++; $display("FAIL basic_hold: got %0d cyc %0d bursts want %0d/1", o.code_cycles, o.bursts, HOLD); end
        n_tests++; if (o.acks !== 1 || o.fails !== 0) begin n_fail++; $display("FAIL basic_ack: got ack %0d fail %0d want 1/0", o.acks, o.fails); end
        n_tests++; if (o.busy_at_ack !== 1'b0 || o.busy_end !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b/%b want 0/0", o.busy_at_ack, o.busy_end); end
        n_tests++; if (o.retry_end !== 2'd0) begin n_fail++; $display("FAIL basic_retry: got %0d want 0", o.retry_end); end
        release_all();
    endtask

    task automatic test_bounce();
        obs_t o;
        int   bounce_cmds;
        state_in = STATE_ALARM;
        bounce_cmds = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 btn_rearm = ((i / 2) % 2 == 0);
            @(negedge clk);
            if (cmd_code !== CMD_IDLE) bounce_cmds++;
        end
        @(posedge clk); #1 btn_rearm = 1'b1;
        observe(CMD_REARM, 2, STATE_ACTIVE, -1, -1, o);
        n_tests++; if (bounce_cmds !== 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d cmd cycles want 0", bounce_cmds); end
        n_tests++; if (o.bursts !== 1 || o.first_cmd !== LAT) begin n_fail++; $display("FAIL bounce_burst: got %0d bursts at %0d want 1 at %0d", o.bursts, o.first_cmd, LAT); end
        n_tests++; if (o.acks !== 1 || o.bad_code !== 0) begin n_fail++; $display("FAIL bounce_ack: got ack %0d bad %0d want 1/0", o.acks, o.bad_code); end
        release_all();
    endtask

    task automatic test_illegal();
        obs_t o;
        state_in = STATE_ACTIVE;
        @(posedge clk); #1 btn_escalate = 1'b1;
        observe(CMD_IDLE, 0, STATE_ACTIVE, -1, -1, o);
        n_tests++; if (o.rejects !== 1) begin n_fail++; $display("FAIL illegal_reject: got %0d want 1", o.rejects); end
        n_tests++; if (o.bad_code !== 0 || o.busy_cycles !== 0) begin n_fail++; $display("FAIL illegal_quiet: got cmd %0d busy %0d want 0/0", o.bad_code, o.busy_cycles); end
        release_all();
    endtask

    task automatic test_timeout();
        obs_t o;
        state_in = STATE_ALARM;
        @(posedge clk); #1 btn_disarm = 1'b1;
        observe(CMD_DISARM, 1000, STATE_INACTIVE, -1, -1, o);
        n_tests++; if (o.bursts !== MAXR + 1 || o.code_cycles !== (MAXR + 1) * HOLD) begin n_fail++; $display("FAIL timeout_bursts: got %0d/%0d want %0d/%0d", o.bursts, o.code_cycles, MAXR + 1, (MAXR + 1) * HOLD); end
        n_tests++; if (o.retry_end !== 2'(MAXR)) begin n_fail++; $display("FAIL timeout_retry: got %0d want %0d", o.retry_end, MAXR); end
        n_tests++; if (o.fails !== 1 || o.acks !== 0 || o.busy_end !== 1'b0) begin n_fail++; $display("FAIL timeout_fail: got fail %0d ack %0d busy %b want 1/0/0", o.fails, o.acks, o.busy_end); end
        release_all();
    endtask

    task automatic test_priority();
        obs_t o;
        int   eb, er;
        bit   ea;
        state_in = STATE_ALARM;
        model_resp(30, eb, ea, er);
        @(posedge clk); #1 btn_disarm = 1'b1; btn_rearm = 1'b1; btn_escalate = 1'b1;
        observe(CMD_DISARM, 30, STATE_INACTIVE, 10, 20, o);
        n_tests++; if (o.bad_code !== 0 || o.first_cmd !== LAT) begin n_fail++; $display("FAIL prio_code: got bad %0d first %0d want 0/%0d", o.bad_code, o.first_cmd, LAT); end
        n_tests++; if (o.rejects !== 1) begin n_fail++; $display("FAIL prio_busy_reject: got %0d want 1", o.rejects); end
        n_tests++; if (o.bursts !== eb || o.acks !== int'(ea) || o.retry_end !== 2'(er)) begin n_fail++; $display("FAIL prio_outcome: got %0d/%0d/%0d want %0d/%0d/%0d", o.bursts, o.acks, o.retry_end, eb, ea, er); end
        release_all();
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            obs_t       o;
            logic [2:0] mask;
            logic [1:0] st, exp_st;
            logic [3:0] code;
            bit         legal, ea;
            int         d, eb, er;
            mask = 3'($urandom_range(1, 7));
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            d = $urandom_range(0, 60);
            if (mask[2]) begin
                code = CMD_DISARM; exp_st = STATE_INACTIVE; legal = (st == STATE_ALARM || st == STATE_EMERGENCY);
            end else if (mask[1]) begin
                code = CMD_REARM; exp_st = STATE_ACTIVE; legal = (st == STATE_ALARM || st == STATE_EMERGENCY);
            end else begin
                code = CMD_ESCALATE; exp_st = STATE_EMERGENCY; legal = (st == STATE_ALARM);
            end
            model_resp(d, eb, ea, er);
            state_in = st;
            @(posedge clk); #1 {btn_disarm, btn_rearm, btn_escalate} = mask;
            observe(legal ? code : CMD_IDLE, d, exp_st, -1, -1, o);
            if (legal) begin
                n_tests++; if (o.bursts !== eb || o.first_cmd !== LAT || o.bad_code !== 0) begin n_fail++; $display("FAIL rand%0d_bursts: got %0d at %0d bad %0d want %0d at %0d (d=%0d)", it, o.bursts, o.first_cmd, o.bad_code, eb, LAT, d); end
                n_tests++; if (o.acks !== int'(ea) || o.fails !== int'(!ea)) begin n_fail++; $display("FAIL rand%0d_result: got ack %0d fail %0d want %0d/%0d (d=%0d)", it, o.acks, o.fails, ea, !ea, d); end
                n_tests++; if (o.retry_end !== 2'(er) || o.busy_end !== 1'b0) begin n_fail++; $display("FAIL rand%0d_retry: got %0d busy %b want %0d/0 (d=%0d)", it, o.retry_end, o.busy_end, er, d); end
            end else begin
                n_tests++; if (o.rejects !== 1 || o.bad_code !== 0 || o.busy_cycles !== 0) begin n_fail++; $display("FAIL rand%0d_illegal: got rej %0d cmd %0d busy %0d want 1/0/0", it, o.rejects, o.bad_code, o.busy_cycles); end
            end
            release_all();
        end
    endtask

    task automatic test_reset_alarm();
        bit seen;
        int fails, cmds, rises, first;
        state_in = STATE_ALARM;
        seen = 1'b0;
        @(posedge clk); #1 btn_disarm = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cmd_code === CMD_DISARM) seen = 1'b1;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL rst_reach_drive: got no 1010 want 1010 within 20 cycles"); end
        #1 reset = 1'b1; btn_disarm = 1'b0;
        #1;
        n_tests++; if (cmd_code !== CMD_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL rst_async: got cmd %b busy %b want 0000/0", cmd_code, busy); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        fails = 0; cmds = 0;
        repeat (20) begin
            @(negedge clk);
            if (fail === 1'b1) fails++;
            if (cmd_code !== CMD_IDLE) cmds++;
        end
        n_tests++; if (fails !== 0 || cmds !== 0) begin n_fail++; $display("FAIL rst_abandon: got fail %0d cmd %0d want 0/0", fails, cmds); end
        @(posedge clk); #1 alarm_in = 1'b1;
        rises = 0; first = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (alarm_rise === 1'b1) begin rises++; if (first < 0) first = c; end
        end
        n_tests++; if (rises !== 1 || first !== 3) begin n_fail++; $display("FAIL alarm_rise: got %0d pulses at %0d want 1 at 3", rises, first); end
        @(posedge clk); #1 alarm_in = 1'b0;
        rises = 0;
        repeat (8) begin
            @(negedge clk);
            if (alarm_rise === 1'b1) rises++;
        end
        n_tests++; if (rises !== 0) begin n_fail++; $display("FAIL alarm_fall: got %0d pulses want 0", rises); end
    endtask

    initial begin
        test_reset();
        test_basic_disarm();
        test_bounce();
        test_illegal();
        test_timeout();
        test_priority();
        test_random();
        test_reset_alarm();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
